lab1_imul_dot_client: RTL and testbench
=======================================

# lab1_imul_dot_client

Request-side initiator for the lab1 integer multiplier val/rdy interface. Accepts a stream of operand pairs and issues each pair as a multiply request. Accumulates the 32-bit products it receives and emits one dot-product result when the pair flagged `last` has been answered. Sits between a test source or upstream unit and any `lab1_imul_IntMul*` instance.

## Interface
- `p_max_inflight`, default 2: maximum multiply requests issued but not yet answered. Legal range 1..15.

- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-high reset
- `in_val`  in  1  operand pair valid
- `in_rdy`  out  1  operand pair accepted this cycle
- `in_msg`  in  64  {a[63:32], b[31:0]}
- `in_last`  in  1  final pair of this dot product; qualified by `in_val`
- `mul_req_val`  out  1  multiply request valid
- `mul_req_rdy`  in  1  multiplier ready
- `mul_req_msg`  out  64  {a, b}; equals `in_msg`
- `mul_resp_val`  in  1  product valid
- `mul_resp_rdy`  out  1  product accepted
- `mul_resp_msg`  in  32  product, low 32 bits
- `out_val`  out  1  dot-product result valid
- `out_rdy`  in  1  consumer ready
- `out_msg`  out  32  accumulated sum mod 2^32

## Operation
- A handshake occurs on any val/rdy pair when both are 1 on a rising edge.
- State machine with three states:
  - ISSUE
    - `mul_req_val = in_val && (inflight < p_max_inflight)`.
    - `in_rdy = mul_req_rdy && (inflight < p_max_inflight)`.
    - The request path is combinational pass-through. An input handshake and a request handshake always coincide.
    - `mul_resp_rdy = 1`.
    - An input handshake with `in_last=1` moves to DRAIN.
  - DRAIN
    - `in_rdy = 0`, `mul_req_val = 0`, `mul_resp_rdy = 1`.
    - When a response handshake brings `inflight` to 0, move to DONE.
  - DONE
    - `out_val = 1`, `out_msg = acc`.
    - `mul_resp_rdy = 0`, `in_rdy = 0`, `mul_req_val = 0`.
    - An output handshake clears `acc` and moves to ISSUE.
- `inflight` counter, width clog2(`p_max_inflight`+1):
  - +1 on a request handshake.
  - -1 on a response handshake.
  - Unchanged when both happen in the same cycle.
- `acc` is 32-bit. It adds `mul_resp_msg` on every response handshake, with wrap-around and no overflow flag.
- Responses are accumulated in arrival order. Addition is order-independent, so no tagging is needed.
- Responses arriving while in ISSUE, before `last`, are accumulated normally.

## Timing
- Reset values:
  - State = ISSUE, `acc` = 0, `inflight` = 0.
  - `out_val` = 0, `mul_resp_rdy` = 1.
  - `mul_req_val` and `in_rdy` follow their ISSUE equations, so both are 0 whenever `in_val` or `mul_req_rdy` is 0 respectively.
- Issue latency: 0 cycles, combinational from `in_val` to `mul_req_val`.
- Result latency: `out_val` rises the cycle after the response handshake that empties `inflight`.
- `out_msg` is stable while `out_val=1 && out_rdy=0`.
- First pair of the next product may be accepted the cycle after the output handshake.
- Reset asserted mid-transaction (any state) returns everything to the reset values on the next evaluation.
  - Responses for requests issued before reset are the environment's responsibility. The multiplier is reset together with this block.
- `in_last` with `p_max_inflight` already reached: no handshake occurs. `last` waits for a free slot.

## Structure
- Shared package `lab1_imul_pkg` holds:
  - State encoding constants `DOT_ISSUE`, `DOT_DRAIN`, `DOT_DONE` (2 bits).
  - Message field macros for a/b slicing of the 64-bit request.
- One natural sub-module: `lab1_imul_InflightCounter`.
  - Parameterized up/down counter with inc and dec inputs, plus `full` and `empty` outputs.
- Accumulator register and FSM stay in the top block.

## Test plan
- Single pair (a=3, b=4, last): `out_msg=12`, `out_val` one cycle after the response.
- Three pairs (2,5), (7,6), (1,1), last on third, zero-delay multiplier: `out_msg=53`.
- Wrap: pairs (0x00010000, 0x00010000) and (1,1), last: `out_msg=0x00000001`.
- Backpressure and limit:
  - `mul_req_rdy=0` for 5 cycles: `in_rdy=0` and no request handshake.
  - Non-responding multiplier: after 2 issues, `mul_req_val=0` and `in_rdy=0` with `in_val=1`.
- Output stall: `out_rdy=0` for 3 cycles in DONE.
  - `out_msg` is held and `in_rdy=0`.
  - Next product (5,5), last: `out_msg=25`, confirming `acc` was cleared.
- Reset in DRAIN with `inflight=1` and `acc=10`: next cycle shows state ISSUE, `out_val=0`, `inflight=0`. A following single pair (2,2) yields `out_msg=4`.

Source files
------------

// File: rtl/lab1_imul_pkg.sv
// Shared types and message helpers for the lab1 integer-multiplier clients.
// Requests carry operand a in the upper half and operand b in the lower half.
package lab1_imul_pkg;

    typedef enum logic [1:0] {
        DOT_ISSUE = 2'd0,
        DOT_DRAIN = 2'd1,
        DOT_DONE  = 2'd2
    } dot_state_t;

    localparam int unsigned OP_W  = 32;
    localparam int unsigned MSG_W = 2 * OP_W;

    function automatic logic [OP_W-1:0] msg_a(input logic [MSG_W-1:0] msg);
        return msg[MSG_W-1:OP_W];
    endfunction

    function automatic logic [OP_W-1:0] msg_b(input logic [MSG_W-1:0] msg);
        return msg[OP_W-1:0];
    endfunction

    function automatic logic [MSG_W-1:0] mk_msg(input logic [OP_W-1:0] a,
                                                input logic [OP_W-1:0] b);
        return {a, b};
    endfunction

endpackage

// File: rtl/lab1_imul_InflightCounter.sv
// Up/down occupancy counter for outstanding multiply requests.
// Simultaneous inc and dec leave the count unchanged.
module lab1_imul_InflightCounter #(
    parameter int unsigned p_max = 2,
    parameter int unsigned p_w   = $clog2(p_max + 1)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           inc,
    input  logic           dec,
    output logic [p_w-1:0] count,
    output logic           full,
    output logic           empty
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (inc && !dec) begin
            count <= count + p_w'(1);
        end else if (dec && !inc) begin
            count <= count - p_w'(1);
        end
    end

    always_comb begin
        full  = (count == p_w'(p_max));
        empty = (count == '0);
    end

endmodule

// File: rtl/lab1_imul_dot_client.sv
// Dot-product initiator: forwards operand pairs as multiply requests and
// accumulates the returned products until the pair flagged last is answered.
module lab1_imul_dot_client
    import lab1_imul_pkg::*;
#(
    parameter int unsigned p_max_inflight = 2
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        in_val,
    output logic        in_rdy,
    input  logic [63:0] in_msg,
    input  logic        in_last,

    output logic        mul_req_val,
    input  logic        mul_req_rdy,
    output logic [63:0] mul_req_msg,

    input  logic        mul_resp_val,
    output logic        mul_resp_rdy,
    input  logic [31:0] mul_resp_msg,

    output logic        out_val,
    input  logic        out_rdy,
    output logic [31:0] out_msg
);

    localparam int unsigned c_w = $clog2(p_max_inflight + 1);

    dot_state_t     state;
    dot_state_t     state_next;
    logic [31:0]    acc;
    logic [c_w-1:0] inflight;
    logic           full;
    logic           empty;
    logic           in_hs;
    logic           req_hs;
    logic           resp_hs;
    logic           out_hs;

    always_comb begin
        in_hs   = in_val && in_rdy;
        req_hs  = mul_req_val && mul_req_rdy;
        resp_hs = mul_resp_val && mul_resp_rdy;
        out_hs  = out_val && out_rdy;
    end

    lab1_imul_InflightCounter #(
        .p_max (p_max_inflight),
        .p_w   (c_w)
    ) u_inflight (
        .clk   (clk),
        .reset (reset),
        .inc   (req_hs),
        .dec   (resp_hs),
        .count (inflight),
        .full  (full),
        .empty (empty)
    );

    assign mul_req_msg = mk_msg(msg_a(in_msg), msg_b(in_msg));
    assign out_msg     = acc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= DOT_ISSUE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        in_rdy       = 1'b0;
        mul_req_val  = 1'b0;
        mul_resp_rdy = 1'b1;
        out_val      = 1'b0;
        case (state)
            DOT_ISSUE: begin
                mul_req_val = in_val && !full;
                in_rdy      = mul_req_rdy && !full;
                if (in_hs && in_last) begin
                    state_next = DOT_DRAIN;
                end
            end
            DOT_DRAIN: begin
                // Draining is entered with at least one request outstanding,
                // so the empty term only guards against an inconsistent count.
                if ((resp_hs && inflight == c_w'(1)) || empty) begin
                    state_next = DOT_DONE;
                end
            end
            DOT_DONE: begin
                out_val      = 1'b1;
                mul_resp_rdy = 1'b0;
                if (out_rdy) begin
                    state_next = DOT_ISSUE;
                end
            end
            default: begin
                state_next = DOT_ISSUE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc <= '0;
        end else if (out_hs) begin
            acc <= '0;
        end else if (resp_hs) begin
            acc <= acc + mul_resp_msg;
        end
    end

endmodule

// File: tb/tb_lab1_imul_dot_client.sv
// Directed bench for lab1_imul_dot_client with a behavioural multiplier
// and a scoreboard of expected dot-product results.
module tb_lab1_imul_dot_client;
    import lab1_imul_pkg::*;

    logic        clk;
    logic        reset;
    logic        in_val;
    logic        in_rdy;
    logic [63:0] in_msg;
    logic        in_last;
    logic        mul_req_val;
    logic        mul_req_rdy;
    logic [63:0] mul_req_msg;
    logic        mul_resp_val;
    logic        mul_resp_rdy;
    logic [31:0] mul_resp_msg;
    logic        out_val;
    logic        out_rdy;
    logic [31:0] out_msg;

    int          n_cmp;
    int          n_err;
    logic [31:0] sb[$];
    logic [31:0] pending[$];
    logic [31:0] exp_acc;
    logic        resp_en;
    int          req_count;

    lab1_imul_dot_client #(
        .p_max_inflight (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_val       (in_val),
        .in_rdy       (in_rdy),
        .in_msg       (in_msg),
        .in_last      (in_last),
        .mul_req_val  (mul_req_val),
        .mul_req_rdy  (mul_req_rdy),
        .mul_req_msg  (mul_req_msg),
        .mul_resp_val (mul_resp_val),
        .mul_resp_rdy (mul_resp_rdy),
        .mul_resp_msg (mul_resp_msg),
        .out_val      (out_val),
        .out_rdy      (out_rdy),
        .out_msg      (out_msg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Multiplier model and output monitor; samples at negedge, updates at posedge+2.
    task automatic monitor();
        int          cyc;
        int          last_resp_cyc;
        logic        prev_out;
        logic        req_fire;
        logic        resp_fire;
        logic [31:0] prod;
        cyc = 0;
        last_resp_cyc = -100;
        prev_out = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                pending.delete();
                mul_resp_val = 1'b0;
                mul_resp_msg = '0;
                prev_out = 1'b0;
                continue;
            end
            req_fire  = mul_req_val && mul_req_rdy;
            resp_fire = mul_resp_val && mul_resp_rdy;
            prod      = msg_a(mul_req_msg) * msg_b(mul_req_msg);
            if (resp_fire) last_resp_cyc = cyc;
            if (out_val && !prev_out) check("result_latency", 32'(cyc - last_resp_cyc), 32'd1);
            prev_out = out_val;
            if (out_val && out_rdy) begin
                if (sb.size() == 0) check("unexpected_out", 32'd1, 32'd0);
                else check("out_msg", out_msg, sb.pop_front());
            end
            @(posedge clk);
            #2;
            if (reset) continue;
            if (req_fire) req_count++;
            if (resp_fire) void'(pending.pop_front());
            if (req_fire) pending.push_back(prod);
            mul_resp_val = resp_en && (pending.size() > 0);
            mul_resp_msg = (pending.size() > 0) ? pending[0] : 32'd0;
        end
    endtask

    task automatic send_pair(input logic [31:0] a, input logic [31:0] b, input logic last);
        logic ok;
        ok = 1'b0;
        in_val  = 1'b1;
        in_msg  = mk_msg(a, b);
        in_last = last;
        exp_acc = exp_acc + a * b;
        if (last) begin
            sb.push_back(exp_acc);
            exp_acc = '0;
        end
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (in_rdy) begin
                ok = 1'b1;
                break;
            end
        end
        check("in_accept", {31'b0, ok}, 32'd1);
        @(posedge clk);
        #1;
        in_val  = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic wait_drained(input string tag);
        logic ok;
        ok = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        check(tag, {31'b0, ok}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic ok;
        int   req_before;
        n_cmp = 0;
        n_err = 0;
        exp_acc = '0;
        req_count = 0;
        reset = 1'b1;
        in_val = 1'b0;
        in_msg = '0;
        in_last = 1'b0;
        mul_req_rdy = 1'b1;
        out_rdy = 1'b1;
        resp_en = 1'b1;
        mul_resp_val = 1'b0;
        mul_resp_msg = '0;
        fork
            monitor();
        join_none

        // Reset state
        @(negedge clk);
        check("rst_out_val", {31'b0, out_val}, 32'd0);
        check("rst_resp_rdy", {31'b0, mul_resp_rdy}, 32'd1);
        check("rst_req_val", {31'b0, mul_req_val}, 32'd0);
        check("rst_state", 32'(dut.state), 32'(DOT_ISSUE));
        check("rst_acc", dut.acc, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Single pair
        send_pair(32'd3, 32'd4, 1'b1);
        wait_drained("single_done");

        // Three pairs, back to back
        send_pair(32'd2, 32'd5, 1'b0);
        send_pair(32'd7, 32'd6, 1'b0);
        send_pair(32'd1, 32'd1, 1'b1);
        wait_drained("three_done");

        // Wrap-around of the accumulator
        send_pair(32'h0001_0000, 32'h0001_0000, 1'b0);
        send_pair(32'd1, 32'd1, 1'b1);
        wait_drained("wrap_done");

        // Request backpressure
        mul_req_rdy = 1'b0;
        in_val = 1'b1;
        in_msg = mk_msg(32'd4, 32'd4);
        in_last = 1'b1;
        req_before = req_count;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_in_rdy", {31'b0, in_rdy}, 32'd0);
        end
        @(posedge clk);
        #1;
        check("bp_no_req", 32'(req_count), 32'(req_before));
        mul_req_rdy = 1'b1;
        send_pair(32'd4, 32'd4, 1'b1);
        wait_drained("bp_done");

        // Inflight limit with a silent multiplier
        resp_en = 1'b0;
        send_pair(32'd1, 32'd2, 1'b0);
        send_pair(32'd3, 32'd4, 1'b0);
        in_val = 1'b1;
        in_msg = mk_msg(32'd5, 32'd6);
        in_last = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("lim_req_val", {31'b0, mul_req_val}, 32'd0);
            check("lim_in_rdy", {31'b0, in_rdy}, 32'd0);
        end
        @(posedge clk);
        #1;
        resp_en = 1'b1;
        send_pair(32'd5, 32'd6, 1'b1);
        wait_drained("lim_done");

        // Output stall
        out_rdy = 1'b0;
        send_pair(32'd6, 32'd7, 1'b1);
        ok = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (out_val) begin
                ok = 1'b1;
                break;
            end
        end
        check("stall_out_val", {31'b0, ok}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            check("stall_hold_msg", out_msg, 32'd42);
            check("stall_in_rdy", {31'b0, in_rdy}, 32'd0);
        end
        @(posedge clk);
        #1;
        out_rdy = 1'b1;
        wait_drained("stall_done");
        send_pair(32'd5, 32'd5, 1'b1);
        wait_drained("after_stall_done");

        // Reset while draining
        send_pair(32'd2, 32'd5, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        resp_en = 1'b0;
        send_pair(32'd3, 32'd3, 1'b1);
        @(negedge clk);
        check("pre_rst_state", 32'(dut.state), 32'(DOT_DRAIN));
        check("pre_rst_inflight", 32'(dut.inflight), 32'd1);
        check("pre_rst_acc", dut.acc, 32'd10);
        @(posedge clk);
        #1;
        reset = 1'b1;
        void'(sb.pop_back());
        exp_acc = '0;
        @(negedge clk);
        check("mid_rst_state", 32'(dut.state), 32'(DOT_ISSUE));
        check("mid_rst_out_val", {31'b0, out_val}, 32'd0);
        check("mid_rst_inflight", 32'(dut.inflight), 32'd0);
        check("mid_rst_acc", dut.acc, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        resp_en = 1'b1;
        send_pair(32'd2, 32'd2, 1'b1);
        wait_drained("post_rst_done");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
